// File: rtl/loopback_sched_pkg.sv
// Shared types and constants for the loopback scheduler: FSM states, channel-tag width,
// default sizing and the round-robin index helper.
package loopback_sched_pkg;

  localparam int CH_W         = 3;
  localparam int CHANNELS_DEF = 7;
  localparam int BURST_DEF    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Channel reached 'off' steps after 'base', wrapping at n; base and off are both below n.
  function automatic int rr_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/loopback_sched_if.sv
// Bundle of the per-channel CDC byte streams, the shared-datapath stream and its return path.
// The slave modport is the scheduler's view; the master modport is the surrounding logic's view.
interface loopback_sched_if
  import loopback_sched_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF
) ();

    logic [8*CHANNELS-1:0] out_data_i;
    logic [CHANNELS-1:0]   out_valid_i;
    logic [CHANNELS-1:0]   out_ready_o;
    logic [7:0]            sh_data_o;
    logic [CH_W-1:0]       sh_ch_o;
    logic                  sh_valid_o;
    logic                  sh_ready_i;
    logic [7:0]            rt_data_i;
    logic [CH_W-1:0]       rt_ch_i;
    logic                  rt_valid_i;
    logic                  rt_ready_o;
    logic [8*CHANNELS-1:0] in_data_o;
    logic [CHANNELS-1:0]   in_valid_o;
    logic [CHANNELS-1:0]   in_ready_i;
    logic                  busy_o;
    logic                  err_o;

    modport slave (
        input  out_data_i, out_valid_i, sh_ready_i, rt_data_i, rt_ch_i, rt_valid_i, in_ready_i,
        output out_ready_o, sh_data_o, sh_ch_o, sh_valid_o, rt_ready_o, in_data_o, in_valid_o,
               busy_o, err_o
    );

    modport master (
        output out_data_i, out_valid_i, sh_ready_i, rt_data_i, rt_ch_i, rt_valid_i, in_ready_i,
        input  out_ready_o, sh_data_o, sh_ch_o, sh_valid_o, rt_ready_o, in_data_o, in_valid_o,
               busy_o, err_o
    );

endinterface

// File: rtl/loopback_sched_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping
// from CHANNELS-1 back to 0.
module loopback_rr_pick
  import loopback_sched_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CH_W-1:0]     ptr,
    output logic [CH_W-1:0]     grant,
    output logic                any
);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        grant = '0;
        any   = |req;
        // Walk from the farthest offset down so the closest requester to ptr wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[CH_W'(rr_index(int'(ptr), i, CHANNELS))]) begin
                grant = CH_W'(rr_index(int'(ptr), i, CHANNELS));
            end
        end
    end

endmodule

// File: rtl/loopback_sched.sv
// Time-shares one byte datapath among CHANNELS CDC OUT streams with round-robin bursts of up to
// BURST bytes, and fans returned bytes back out by tag. Optional LOOPBACK_SCHED_STATS_EN adds
// per-channel beat counters readable through stat_sel_i / stat_cnt_o.
module loopback_sched
  import loopback_sched_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int BURST    = BURST_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    loopback_sched_if.slave bus
`ifdef LOOPBACK_SCHED_STATS_EN
    ,
    input  logic [2:0]      stat_sel_i,
    output logic [15:0]     stat_cnt_o
`endif
);

    localparam int CNT_W = $clog2(BURST + 1);

    state_t          state, state_nxt;
    logic [CH_W-1:0] ptr, grant, pick;
    logic [CNT_W-1:0] count;
    logic            pick_any, beat, last_beat, exit_xfer, rt_ch_ok;

    loopback_rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req   (bus.out_valid_i),
        .ptr   (ptr),
        .grant (pick),
        .any   (pick_any)
    );

    assign beat      = (state == XFER) && bus.out_valid_i[grant] && bus.sh_ready_i;
    assign last_beat = beat && (count == CNT_W'(BURST - 1));
    // A dropped valid means no byte is on offer, so leaving then never splits a byte.
    assign exit_xfer = (state == XFER) && (!bus.out_valid_i[grant] || last_beat);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                grant <= pick;
                count <= '0;
            end else if (beat) begin
                count <= count + 1'b1;
            end
            if (exit_xfer) begin
                ptr <= (grant == CH_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_any)  state_nxt = XFER;
            XFER: if (exit_xfer) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_ready_o = '0;
        bus.sh_valid_o  = 1'b0;
        bus.sh_data_o   = bus.out_data_i[8*grant +: 8];
        bus.sh_ch_o     = grant;
        bus.busy_o      = (state == XFER);
        if (state == XFER) begin
            bus.sh_valid_o         = bus.out_valid_i[grant];
            bus.out_ready_o[grant] = bus.sh_ready_i;
        end
    end

    // Return path: independent of the FSM; bad tags are swallowed and flagged.
    assign rt_ch_ok      = int'(bus.rt_ch_i) < CHANNELS;
    assign bus.in_data_o = {CHANNELS{bus.rt_data_i}};

    always_comb begin
        bus.in_valid_o = '0;
        bus.rt_ready_o = 1'b1;
        if (rt_ch_ok) begin
            bus.in_valid_o[bus.rt_ch_i] = bus.rt_valid_i;
            bus.rt_ready_o              = bus.in_ready_i[bus.rt_ch_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.err_o <= 1'b0;
        end else if (bus.rt_valid_i && !rt_ch_ok) begin
            bus.err_o <= 1'b1;
        end
    end

`ifdef LOOPBACK_SCHED_STATS_EN
    logic [15:0] stat_mem [CHANNELS];

    // NOTE: the counters are plain flops rather than a RAM macro, so they can take the synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) stat_mem[c] <= '0;
            stat_cnt_o <= '0;
        end else begin
            if (beat) stat_mem[grant] <= stat_mem[grant] + 16'd1;
            stat_cnt_o <= (int'(stat_sel_i) < CHANNELS) ? stat_mem[stat_sel_i] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_loopback_sched.sv
// Scoreboard bench for loopback_sched: per-channel byte sources, a queue-level arbitration model
// that predicts the shared-datapath byte stream, and a negedge monitor that checks it.
module tb_loopback_sched;
    import loopback_sched_pkg::*;

    localparam int CH        = CHANNELS_DEF;
    localparam int BURST     = BURST_DEF;
    localparam int END_NONE  = 0;
    localparam int END_CAP   = 1;
    localparam int END_DRAIN = 2;

    typedef struct {
        int         ch;
        logic [7:0] data;
        bit         first;
        int         end_t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    loopback_sched_if #(.CHANNELS(CH)) bus ();

`ifdef LOOPBACK_SCHED_STATS_EN
    logic [2:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    loopback_sched #(.CHANNELS(CH), .BURST(BURST)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
`ifdef LOOPBACK_SCHED_STATS_EN
        ,
        .stat_sel_i (stat_sel),
        .stat_cnt_o (stat_cnt)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    exp_t       sb[$];
    logic [7:0] src_mem [CH][256];
    int         src_head [CH] = '{default: 0};
    int         src_tail [CH] = '{default: 0};
    bit         hs [CH] = '{default: 1'b0};
    int         m_ptr = 0;
    int         ready_mode = 0;
    bit         err_exp = 1'b0;
    int         beat_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int c, input int n, input logic [7:0] first_byte, input bit rnd);
        for (int i = 0; i < n; i++) begin
            src_mem[c][src_tail[c] % 256] = rnd ? 8'($urandom) : first_byte + 8'(i);
            src_tail[c]++;
        end
    endtask

    // Reference: bytes already queued drain as round-robin grants of at most BURST bytes each.
    task automatic predict();
        int pos [CH];
        int found;
        int n;
        for (int c = 0; c < CH; c++) pos[c] = src_head[c];
        forever begin
            found = -1;
            for (int k = 0; k < CH; k++) begin
                int c;
                c = (m_ptr + k) % CH;
                if (found < 0 && pos[c] < src_tail[c]) found = c;
            end
            if (found < 0) break;
            n = src_tail[found] - pos[found];
            if (n > BURST) n = BURST;
            for (int i = 0; i < n; i++) begin
                sb.push_back('{found, src_mem[found][(pos[found] + i) % 256], i == 0,
                               (i == n - 1) ? ((n == BURST) ? END_CAP : END_DRAIN) : END_NONE});
            end
            pos[found] += n;
            m_ptr = (found + 1) % CH;
        end
    endtask

    function automatic bit pending();
        for (int c = 0; c < CH; c++) if (src_head[c] != src_tail[c]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || pending() || bus.busy_o) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({"drain_", name}, sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    // Source side: retire bytes handshaked at the last edge, then present the next head byte.
    initial begin
        bus.out_valid_i = '0;
        bus.out_data_i  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < CH; c++) begin
                if (hs[c]) src_head[c]++;
                bus.out_valid_i[c]       = (src_head[c] != src_tail[c]);
                bus.out_data_i[8*c +: 8] = src_mem[c][src_head[c] % 256];
            end
        end
    end

    initial begin
        int phase;
        phase = 0;
        bus.sh_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.sh_ready_i = ($urandom_range(0, 3) != 0);
                2:       bus.sh_ready_i = (phase % 4 == 0) || (phase % 4 == 3);
                default: bus.sh_ready_i = 1'b1;
            endcase
            phase = (ready_mode == 2) ? phase + 1 : 0;
        end
    end

    // Monitor: compares the shared stream against the scoreboard and checks FSM timing rules.
    initial begin
        bit exp_busy_next;
        bit rst_chk;
        int idle_in;
        int beats_in_grant;
        exp_busy_next  = 1'b0;
        rst_chk        = 1'b0;
        idle_in        = 0;
        beats_in_grant = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) hs[c] = bus.out_valid_i[c] && bus.out_ready_o[c];
            if (rst_chk) begin
                check("rst_busy", bus.busy_o, 0);
                check("rst_sh_valid", bus.sh_valid_o, 0);
                check("rst_out_ready", bus.out_ready_o, 0);
                check("rst_err", bus.err_o, 0);
            end
            if (exp_busy_next) check("arb_latency", bus.busy_o, 1);
            if (idle_in == 2) begin
                check("drain_exit_busy", bus.busy_o, 1);
                check("drain_exit_valid", bus.sh_valid_o, 0);
            end else if (idle_in == 1) begin
                check("exit_idle", bus.busy_o, 0);
            end
            if (idle_in > 0) idle_in--;
            if (!bus.busy_o) begin
                beats_in_grant = 0;
                check("idle_sh_valid", bus.sh_valid_o, 0);
                check("idle_out_ready", bus.out_ready_o, 0);
            end
            check("err_flag", bus.err_o, err_exp);
            if (bus.sh_valid_o) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: ch %0d data 0x%0h, scoreboard empty",
                             bus.sh_ch_o, bus.sh_data_o);
                end else begin
                    check("sh_ch", bus.sh_ch_o, sb[0].ch);
                    check("sh_data", bus.sh_data_o, sb[0].data);
                    check("out_ready", bus.out_ready_o, bus.sh_ready_i ? (32'd1 << sb[0].ch) : 0);
                    if (bus.sh_ready_i) begin
                        check("burst_start", beats_in_grant == 0, sb[0].first);
                        idle_in = (sb[0].end_t == END_CAP) ? 1 : (sb[0].end_t == END_DRAIN) ? 2 : 0;
                        beats_in_grant++;
                        beat_total++;
                        void'(sb.pop_front());
                    end
                end
            end
            exp_busy_next = !bus.busy_o && (|bus.out_valid_i) && !rst;
            rst_chk       = rst;
            if (rst) idle_in = 0;
            err_exp = rst ? 1'b0 : (err_exp | (bus.rt_valid_i && int'(bus.rt_ch_i) >= CH));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int t;
        logic [CH-1:0] rdy;
        int ch;
        int pick;
        rst             = 1'b1;
        bus.rt_valid_i  = 1'b0;
        bus.rt_data_i   = '0;
        bus.rt_ch_i     = '0;
        bus.in_ready_i  = '0;
`ifdef LOOPBACK_SCHED_STATS_EN
        stat_sel = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Lone requester, then a 0/1 pair that exposes ptr=1.
        sync(); load(0, 7, 8'h01, 1'b0); predict(); wait_drain("ch0_seq");
        sync(); load(0, 1, 8'hA0, 1'b0); load(1, 1, 8'hB0, 1'b0); predict(); wait_drain("ptr_after_ch0");

        sync(); rst = 1'b1;
        sync(); rst = 1'b0; m_ptr = 0;

        sync(); load(0, 3, 8'h10, 1'b0); load(3, 3, 8'h30, 1'b0); load(6, 3, 8'h60, 1'b0);
        predict(); wait_drain("ch036");
        sync(); load(0, 2, 8'h70, 1'b0); predict(); wait_drain("ch0_again");

        sync(); load(1, 16, 8'h21, 1'b0); predict(); wait_drain("burst_cap");

        ready_mode = 2;
        sync(); load(5, 6, 8'h51, 1'b0); predict(); wait_drain("stall");
        ready_mode = 0;

        // Return path: tag 2 gated by in_ready[2], then illegal tag 7.
        sync();
        bus.rt_ch_i = 3'd2; bus.rt_data_i = 8'h5A; bus.rt_valid_i = 1'b1; bus.in_ready_i = '0;
        #1;
        check("rt2_in_valid", bus.in_valid_o, 32'h04);
        check("rt2_in_data", bus.in_data_o[23:16], 8'h5A);
        check("rt2_ready_low", bus.rt_ready_o, 0);
        bus.in_ready_i = 7'b0000100;
        #1;
        check("rt2_ready_high", bus.rt_ready_o, 1);
        sync();
        bus.rt_ch_i = 3'd7; bus.rt_data_i = 8'hA5; bus.in_ready_i = '0;
        #1;
        check("rt7_in_valid", bus.in_valid_o, 0);
        check("rt7_ready", bus.rt_ready_o, 1);
        sync();
        bus.rt_valid_i = 1'b0;
        #1;
        check("rt7_err_sticky", bus.err_o, 1);

        for (int i = 0; i < 40; i++) begin
            sync();
            ch             = $urandom_range(0, 7);
            rdy            = CH'($urandom);
            bus.rt_ch_i    = 3'(ch);
            bus.rt_data_i  = 8'($urandom);
            bus.rt_valid_i = 1'($urandom);
            bus.in_ready_i = rdy;
            pick           = $urandom_range(0, CH - 1);
            #1;
            check("rt_rand_valid", bus.in_valid_o,
                  (ch < CH && bus.rt_valid_i) ? (32'd1 << ch) : 0);
            check("rt_rand_ready", bus.rt_ready_o, (ch < CH) ? rdy[ch % CH] : 1'b1);
            check("rt_rand_data", bus.in_data_o[8*pick +: 8], bus.rt_data_i);
        end
        sync();
        bus.rt_valid_i = 1'b0;

        // Randomised batches under random back-pressure.
        for (int b = 0; b < 25; b++) begin
            ready_mode = (b % 3 == 0) ? 0 : 1;
            sync();
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 1) == 1) load(c, $urandom_range(1, 20), 8'h00, 1'b1);
            end
            predict();
            wait_drain("random");
        end
        ready_mode = 0;

        // Reset during the 4th beat of a channel-4 burst, with ptr parked at 6 beforehand.
        sync(); load(5, 1, 8'hE0, 1'b0); predict(); wait_drain("pre_rst");
        sync(); load(4, 8, 8'hC1, 1'b0); predict();
        base = beat_total;
        t    = 0;
        while (beat_total < base + 3 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("rst_beats_seen", beat_total - base, 3);
        #1;
        rst = 1'b1;
        load(2, 2, 8'hD1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        sb.delete();
        m_ptr = 0;
        predict();
        wait_drain("post_rst");

        repeat (3) sync();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
